burst_client: RTL and testbench

Request-side agent for one port of the token-ring arbiter. It buffers burst jobs from local logic in a small FIFO and drives the controller's four-phase `req`/`ack` handshake for each job. While it holds the token it emits one data beat per cycle, then releases the token. It replaces the free-running random client with a deterministic, queue-driven requester and sits directly upstream of one controller instance.

---
 rtl/burst_client.sv | 163 ++++++++++++++++
 tb/tb_burst_client.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_client.sv
// burst_client: queues burst jobs in a small FIFO and runs the four-phase req/ack
// token handshake, emitting one tagged data beat per cycle while the token is held.
module burst_client #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int TAG_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [LEN_W-1:0]           in_len,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       in_ready,
    output logic                       req,
    input  logic                       ack,
    output logic                       beat,
    output logic [TAG_W-1:0]           beat_tag,
    output logic                       beat_last,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        NO_REQ     = 2'd0,
        REQ        = 2'd1,
        HAVE_TOKEN = 2'd2,
        RELEASE    = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               req_reg, req_next;
    logic               beat_reg, beat_next;
    logic               last_reg, last_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic [LEN_W-1:0]   rem_reg, rem_next;
    logic [TAG_W-1:0]   tag_reg, tag_next;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]   level_reg;

    logic [LEN_W+TAG_W-1:0] mem [DEPTH];
    logic [LEN_W+TAG_W-1:0] head;
    logic                   full, empty, push, pop;

    assign full  = (level_reg == LVL_W'(DEPTH));
    assign empty = (level_reg == '0);
    assign push  = in_valid && !full;
    assign head  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_len, in_tag};
        end
    end

    // Pop is held off during the done cycle so jobs are spaced by one idle cycle.
    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        beat_next  = beat_reg;
        last_next  = last_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        rem_next   = rem_reg;
        tag_next   = tag_reg;
        pop        = 1'b0;
        case (state_reg)
            NO_REQ: begin
                if (ack) begin
                    err_next = 1'b1;
                end
                if (!empty && !done_reg) begin
                    pop        = 1'b1;
                    rem_next   = head[LEN_W+TAG_W-1:TAG_W];
                    tag_next   = head[TAG_W-1:0];
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack) begin
                    beat_next  = 1'b1;
                    last_next  = (rem_reg == '0);
                    state_next = HAVE_TOKEN;
                end
            end
            HAVE_TOKEN: begin
                if (!ack) begin
                    err_next   = 1'b1;
                    beat_next  = 1'b0;
                    last_next  = 1'b0;
                    req_next   = 1'b0;
                    state_next = RELEASE;
                end else if (rem_reg == '0) begin
                    beat_next  = 1'b0;
                    last_next  = 1'b0;
                    req_next   = 1'b0;
                    state_next = RELEASE;
                end else begin
                    rem_next  = rem_reg - LEN_W'(1);
                    beat_next = 1'b1;
                    last_next = (rem_reg == LEN_W'(1));
                end
            end
            RELEASE: begin
                if (!ack) begin
                    done_next  = 1'b1;
                    state_next = NO_REQ;
                end
            end
            default: state_next = NO_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= NO_REQ;
            req_reg    <= 1'b0;
            beat_reg   <= 1'b0;
            last_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            rem_reg    <= '0;
            tag_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            beat_reg  <= beat_next;
            last_reg  <= last_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            rem_reg   <= rem_next;
            tag_reg   <= tag_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign in_ready  = !full;
    assign req       = req_reg;
    assign beat      = beat_reg;
    assign beat_last = last_reg;
    assign beat_tag  = tag_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign level     = level_reg;

endmodule

// File: tb/tb_burst_client.sv
// tb_burst_client: table-driven jobs plus hand sequences for FIFO fill, grant
// withdrawal and async reset; beats are checked against a scoreboard queue.
module tb_burst_client;
    localparam int DEPTH = 4;
    localparam int LEN_W = 4;
    localparam int TAG_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [LEN_W-1:0] in_len;
    logic [TAG_W-1:0] in_tag;
    logic             in_ready;
    logic             req;
    logic             ack;
    logic             beat;
    logic [TAG_W-1:0] beat_tag;
    logic             beat_last;
    logic             done;
    logic             err;
    logic [$clog2(DEPTH):0] level;

    burst_client #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_len    (in_len),
        .in_tag    (in_tag),
        .in_ready  (in_ready),
        .req       (req),
        .ack       (ack),
        .beat      (beat),
        .beat_tag  (beat_tag),
        .beat_last (beat_last),
        .done      (done),
        .err       (err),
        .level     (level)
    );

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             last;
    } beat_exp_t;

    typedef struct {
        logic [LEN_W-1:0] len;
        logic [TAG_W-1:0] tag;
        int               delay;
        int               exp_beats;
        int               exp_req_ack;
    } vec_t;

    beat_exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   beat_cnt = 0;
    int   done_cnt = 0;
    int   req_ack_cnt = 0;
    logic force_ack_low = 1'b0;
    int   ack_delay = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controller model: grants ack_delay cycles after req, drops ack one cycle after req falls.
    initial begin
        int   cnt;
        logic req_d;
        cnt   = 0;
        req_d = 1'b0;
        ack   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || force_ack_low) begin
                ack = 1'b0;
                cnt = 0;
            end else if (ack) begin
                if (!req_d) ack = 1'b0;
            end else if (req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    ack = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
            req_d = req;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic void sb_job(input logic [TAG_W-1:0] tag, input int n, input logic ends_last);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{tag: tag, last: (ends_last && (i == n - 1))});
        end
    endfunction

    task automatic clear_counts();
        beat_cnt    = 0;
        done_cnt    = 0;
        req_ack_cnt = 0;
    endtask

    // One cycle: advance to the falling edge and score whatever the DUT produced.
    task automatic tick();
        beat_exp_t e;
        @(negedge clk);
        if (req && ack) req_ack_cnt++;
        if (done) done_cnt++;
        if (beat) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: actual tag %0h, required no beat", beat_tag);
            end else begin
                e = exp_q.pop_front();
                check("beat_tag", beat_tag, e.tag);
                check("beat_last", beat_last, e.last);
                $display("beat tag=%0h last=%0b", beat_tag, beat_last);
            end
        end else if (beat_last) begin
            check("beat_last_without_beat", beat_last, 0);
        end
    endtask

    task automatic push_job(input logic [LEN_W-1:0] len, input logic [TAG_W-1:0] tag,
                            input logic exp_acc);
        check("in_ready_before_push", in_ready, exp_acc);
        in_valid = 1'b1;
        in_len   = len;
        in_tag   = tag;
        tick();
        in_valid = 1'b0;
        $display("push len=%0d tag=%0h expect_accept=%0b level=%0d", len, tag, exp_acc, level);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (done_cnt < n && t < 400) begin
            tick();
            t++;
        end
        check("done_count_reached", done_cnt, n);
    endtask

    task automatic wait_beats(input int n);
        int t = 0;
        while (beat_cnt < n && t < 200) begin
            tick();
            t++;
        end
        check("beat_count_reached", beat_cnt, n);
    endtask

    initial begin
        vec_t vecs [4];
        vecs[0] = '{len: 4'd2,  tag: 8'h5A, delay: 2, exp_beats: 3,  exp_req_ack: 4};
        vecs[1] = '{len: 4'd0,  tag: 8'hC3, delay: 1, exp_beats: 1,  exp_req_ack: 2};
        vecs[2] = '{len: 4'd15, tag: 8'h11, delay: 3, exp_beats: 16, exp_req_ack: 17};
        vecs[3] = '{len: 4'd5,  tag: 8'hA0, delay: 1, exp_beats: 6,  exp_req_ack: 7};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_len   = '0;
        in_tag   = '0;
        #1;
        check("reset_req", req, 0);
        check("reset_beat", beat, 0);
        check("reset_beat_last", beat_last, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_beat_tag", beat_tag, 0);
        check("reset_level", level, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single jobs from the table, each from an idle, empty client.
        for (int v = 0; v < 4; v++) begin
            clear_counts();
            ack_delay = vecs[v].delay;
            sb_job(vecs[v].tag, vecs[v].exp_beats, 1'b1);
            push_job(vecs[v].len, vecs[v].tag, 1'b1);
            check("no_bypass_req", req, 0);
            check("level_after_push", level, 1);
            tick();
            check("req_after_pop", req, 1);
            check("level_after_pop", level, 0);
            wait_done(1);
            tick();
            check("single_done_pulse", done_cnt, 1);
            check("beats_per_job", beat_cnt, vecs[v].exp_beats);
            check("req_ack_cycles", req_ack_cnt, vecs[v].exp_req_ack);
            check("beats_outstanding", exp_q.size(), 0);
            check("err_clean", err, 0);
            $display("job tag=%0h len=%0d beats=%0d done=%0d", vecs[v].tag, vecs[v].len, beat_cnt, done_cnt);
        end

        // Fill the FIFO with the grant held off, then serve in order.
        clear_counts();
        force_ack_low = 1'b1;
        ack_delay     = 1;
        for (int j = 0; j < 5; j++) begin
            sb_job(8'h10 + 8'(j), (j % 3) + 1, 1'b1);
            push_job(LEN_W'(j % 3), 8'h10 + 8'(j), 1'b1);
        end
        check("full_level", level, 4);
        check("full_in_ready", in_ready, 0);
        push_job(4'd3, 8'hEE, 1'b0);
        check("refused_push_level", level, 4);
        force_ack_low = 1'b0;
        wait_done(5);
        check("fifo_total_beats", beat_cnt, 9);
        check("fifo_drained_level", level, 0);
        check("fifo_drained_in_ready", in_ready, 1);
        check("fifo_err_clean", err, 0);
        check("fifo_beats_outstanding", exp_q.size(), 0);

        // Grant withdrawn with three beats left: job cut short, err sticky.
        clear_counts();
        ack_delay = 1;
        sb_job(8'h77, 4, 1'b0);
        push_job(4'd6, 8'h77, 1'b1);
        wait_beats(3);
        force_ack_low = 1'b1;
        wait_done(1);
        force_ack_low = 1'b0;
        check("abort_beats", beat_cnt, 4);
        check("abort_err", err, 1);
        check("abort_beats_outstanding", exp_q.size(), 0);
        clear_counts();
        sb_job(8'h88, 2, 1'b1);
        push_job(4'd1, 8'h88, 1'b1);
        wait_done(1);
        check("after_abort_beats", beat_cnt, 2);
        check("err_sticky", err, 1);

        // Asynchronous reset in the middle of a burst with a job still queued.
        clear_counts();
        ack_delay = 1;
        sb_job(8'h3C, 10, 1'b1);
        push_job(4'd9, 8'h3C, 1'b1);
        push_job(4'd2, 8'h4D, 1'b1);
        check("push_pop_same_edge_level", level, 1);
        wait_beats(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_req", req, 0);
        check("async_rst_beat", beat, 0);
        check("async_rst_beat_last", beat_last, 0);
        check("async_rst_level", level, 0);
        check("async_rst_in_ready", in_ready, 1);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_level", level, 0);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_req", req, 0);
        check("post_rst_err", err, 0);
        clear_counts();
        ack_delay = 2;
        sb_job(8'hE1, 4, 1'b1);
        push_job(4'd3, 8'hE1, 1'b1);
        wait_done(1);
        check("post_rst_job_beats", beat_cnt, 4);
        check("post_rst_beats_outstanding", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
